// File: rtl/pciecfg_pkg.sv
// pciecfg_pkg: shared types and constants of the PCIe config-access reply path.
package pciecfg_pkg;
  localparam int PCIECFG_PKT_BYTES = 60;
  localparam int PCIECFG_PKT_BITS = PCIECFG_PKT_BYTES * 8;
  localparam int PCIECFG_TX_NWORDS = (PCIECFG_PKT_BYTES + 7) / 8;
  function automatic logic [7:0] last_keep(input int bytes);
    int r;
    r = bytes % 8;
    return r == 0 ? 8'hFF : 8'((1 << r) - 1);
  endfunction
  localparam logic [7:0] PCIECFG_TX_LAST_KEEP = last_keep(PCIECFG_PKT_BYTES);
  typedef struct packed {
    logic                        data_valid;
    logic [PCIECFG_PKT_BITS-1:0] pkt;
  } FIFO_PCIECFG_T;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SEND} tx_state_e;
endpackage

// File: rtl/pciecfg_tx_if.sv
// pciecfg_tx_if: response-FIFO read port plus the 64-bit TX stream toward the MAC.
interface pciecfg_tx_if;
  import pciecfg_pkg::*;
  logic          fifo_pciecfg_rd_en;
  logic          fifo_pciecfg_empty;
  FIFO_PCIECFG_T fifo_pciecfg_dout;
  logic [63:0]   tx_tdata;
  logic [7:0]    tx_tkeep;
  logic          tx_tvalid;
  logic          tx_tlast;
  logic          tx_tready;
  logic          tx_busy;
  modport master (
    output fifo_pciecfg_rd_en, tx_tdata, tx_tkeep, tx_tvalid, tx_tlast, tx_busy,
    input  fifo_pciecfg_empty, fifo_pciecfg_dout, tx_tready
  );
  modport slave (
    input  fifo_pciecfg_rd_en, tx_tdata, tx_tkeep, tx_tvalid, tx_tlast, tx_busy,
    output fifo_pciecfg_empty, fifo_pciecfg_dout, tx_tready
  );
endinterface

// File: rtl/pciecfg_tx_stats.sv
// pciecfg_tx_stats: saturating frame/bubble counters (used with PCIECFG_TX_STATS_EN).
module pciecfg_tx_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_inc,
  input  logic        bubble_inc,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_bubbles
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stat_frames <= '0;
      stat_bubbles <= '0;
    end else begin
      if (frame_inc && !(&stat_frames)) stat_frames <= stat_frames + 1'b1;
      if (bubble_inc && !(&stat_bubbles)) stat_bubbles <= stat_bubbles + 1'b1;
    end
endmodule

// File: rtl/pciecfg_tx.sv
// pciecfg_tx: drains the response FIFO, drops bubbles, streams each reply as 64-bit words.
// Define PCIECFG_TX_STATS_EN to add the stat_frames/stat_bubbles counter ports.
module pciecfg_tx
  import pciecfg_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int PKT_BYTES = PCIECFG_PKT_BYTES
) (
  input  logic         clk,
  input  logic         rst,
  pciecfg_tx_if.master bus
`ifdef PCIECFG_TX_STATS_EN
  ,
  output logic [31:0]  stat_frames,
  output logic [31:0]  stat_bubbles
`endif
);
  localparam int NW = PCIECFG_TX_NWORDS;
  localparam int IW = NW > 1 ? $clog2(NW) : 1;
  localparam int PAD = NW * DATA_W - PCIECFG_PKT_BITS;
  localparam logic [IW-1:0] LAST = IW'(NW - 1);
  localparam logic [1:0] IDLE = TX_IDLE;
  localparam logic [1:0] LOAD = TX_LOAD;
  localparam logic [1:0] SEND = TX_SEND;
  if (DATA_W != 64 || PKT_BYTES != PCIECFG_PKT_BYTES) begin : g_bad_cfg
    $error("pciecfg_tx: DATA_W must be 64 and PKT_BYTES must match FIFO_PCIECFG_T");
  end
  logic [1:0]                  state;
  logic [IW-1:0]               idx;
  logic [PCIECFG_PKT_BITS-1:0] pkt;
  logic                        rd_en;
  logic                        send, last, hs;
  logic [NW*DATA_W-1:0]        padded;
  logic [DATA_W-1:0]           chunk, data;
  // Packet is MSB-first; left-align it so word k is the k-th DATA_W slice from the top.
  always_comb begin
    send = state == SEND;
    last = send && idx == LAST;
    hs = send && bus.tx_tready;
    padded = (NW * DATA_W)'(pkt) << PAD;
    chunk = DATA_W'(padded >> (DATA_W * (NW - 1 - int'(idx))));
    data = '0;
    for (int i = 0; i < DATA_W / 8; i++) data[8*i +: 8] = send ? chunk[DATA_W-1-8*i -: 8] : 8'h00;
  end
  assign bus.fifo_pciecfg_rd_en = rd_en;
  assign bus.tx_tvalid = send;
  assign bus.tx_busy = send;
  assign bus.tx_tlast = last;
  assign bus.tx_tkeep = last ? PCIECFG_TX_LAST_KEEP : {8{send}};
  assign bus.tx_tdata = data;
  // rd_en is issued from IDLE and the entry lands in LOAD; a bubble may re-issue straight away.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      pkt <= '0;
      rd_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_en <= !rd_en && !bus.fifo_pciecfg_empty;
          if (rd_en) state <= LOAD;
        end
        LOAD: begin
          idx <= '0;
          if (bus.fifo_pciecfg_dout.data_valid) begin
            pkt <= bus.fifo_pciecfg_dout.pkt;
            state <= SEND;
          end else begin
            rd_en <= !bus.fifo_pciecfg_empty;
            state <= IDLE;
          end
        end
        SEND:
          if (hs) begin
            if (last) state <= IDLE;
            else idx <= idx + 1'b1;
          end
        default: begin
          state <= IDLE;
          rd_en <= 1'b0;
        end
      endcase
    end
`ifdef PCIECFG_TX_STATS_EN
  pciecfg_tx_stats u_stats (
    .clk(clk),
    .rst(rst),
    .frame_inc(hs && last),
    .bubble_inc(state == LOAD && !bus.fifo_pciecfg_dout.data_valid),
    .stat_frames(stat_frames),
    .stat_bubbles(stat_bubbles)
  );
`endif
endmodule
